// File: rtl/sik_defs.sv
// Shared SIK definitions: opcodes, NoArg codes, instruction fields, state encoding.
// Used by both the fetch/decode front end and the execute stage.
package sik_defs;

    localparam int WORDSIZE  = 16;
    localparam int OPCODE_HI = 15;
    localparam int OPCODE_LO = 12;
    localparam int ARG_HI    = 11;
    localparam int ARG_LO    = 0;

    localparam logic [3:0] OP_NOARG = 4'd0;
    localparam logic [3:0] OP_JUMP  = 4'd1;
    localparam logic [3:0] OP_JUMPT = 4'd2;
    localparam logic [3:0] OP_JUMPF = 4'd3;
    localparam logic [3:0] OP_CALL  = 4'd4;
    localparam logic [3:0] OP_LOAD  = 4'd5;
    localparam logic [3:0] OP_STORE = 4'd6;
    localparam logic [3:0] OP_PRE   = 4'd7;
    localparam logic [3:0] OP_PUSH  = 4'd8;
    localparam logic [3:0] OP_PUT   = 4'd9;

    localparam logic [11:0] NA_RET  = 12'h001;
    localparam logic [11:0] NA_ADD  = 12'h002;
    localparam logic [11:0] NA_SUB  = 12'h004;
    localparam logic [11:0] NA_AND  = 12'h008;
    localparam logic [11:0] NA_OR   = 12'h010;
    localparam logic [11:0] NA_XOR  = 12'h020;
    localparam logic [11:0] NA_INV  = 12'h040;
    localparam logic [11:0] NA_SHL  = 12'h080;
    localparam logic [11:0] NA_SHR  = 12'h100;
    localparam logic [11:0] NA_SYS  = 12'h200;
    localparam logic [11:0] NA_DUP  = 12'h400;
    localparam logic [11:0] NA_DROP = 12'h800;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_HALTED
    } state_t;

    // Every NoArg code is a single set bit of the 12-bit argument.
    function automatic logic is_noarg(input logic [11:0] arg);
        return $onehot(arg);
    endfunction

endpackage

// File: rtl/sik_imm_gen.sv
// Immediate builder: merges a pending Pre nibble with the 12-bit argument,
// otherwise sign-extends the argument.
module sik_imm_gen
    import sik_defs::*;
(
    input  logic [11:0]         arg,
    input  logic [3:0]          pre_reg,
    input  logic                pre_loaded,
    output logic [WORDSIZE-1:0] imm,
    output logic                pre_used
);

    always_comb begin
        imm      = {{4{arg[11]}}, arg};
        pre_used = 1'b0;
        if (pre_loaded) begin
            imm      = {pre_reg, arg};
            pre_used = 1'b1;
        end
    end

endmodule

// File: rtl/sik_fetch_decode.sv
// SIK fetch/decode front end: fetch, Pre folding, valid/ready hand-off.
// Optional SIK_ILLEGAL_TRAP_EN adds the illegal output and traps bad words.
module sik_fetch_decode
    import sik_defs::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_rd,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_op,
    output logic [11:0]     out_arg,
    output logic [15:0]     out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic            out_pre_used,
    output logic            halted
`ifdef SIK_ILLEGAL_TRAP_EN
    ,
    output logic            illegal
`endif
);

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [3:0]      pre_reg, pre_reg_n;
    logic            pre_loaded, pre_loaded_n;
    logic            valid_n;
    logic [3:0]      op_n;
    logic [11:0]     arg_n;
    logic [15:0]     imm_n;
    logic [PC_W-1:0] opc_n;
    logic            pu_n;

    logic [3:0]      in_op;
    logic [11:0]     in_arg;
    logic [15:0]     imm_w;
    logic            pre_used_w;
    logic            xfer;
    logic            is_sys;

    assign in_op  = imem_data[OPCODE_HI:OPCODE_LO];
    assign in_arg = imem_data[ARG_HI:ARG_LO];
    assign xfer   = out_valid && out_ready;
    assign is_sys = (out_op == OP_NOARG) && (out_arg == NA_SYS);

    assign imem_rd   = reset && (state == ST_FETCH);
    assign imem_addr = pc;
    assign halted    = (state == ST_HALTED);

`ifdef SIK_ILLEGAL_TRAP_EN
    logic bad;
    logic illegal_n;
    assign bad = (in_op > OP_PUT) ||
                 ((in_op == OP_NOARG) && !is_noarg(in_arg));
`endif

    sik_imm_gen u_imm (
        .arg        (in_arg),
        .pre_reg    (pre_reg),
        .pre_loaded (pre_loaded),
        .imm        (imm_w),
        .pre_used   (pre_used_w)
    );

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pre_reg_n    = pre_reg;
        pre_loaded_n = pre_loaded;
        valid_n      = out_valid;
        op_n         = out_op;
        arg_n        = out_arg;
        imm_n        = out_imm;
        opc_n        = out_pc;
        pu_n         = out_pre_used;
`ifdef SIK_ILLEGAL_TRAP_EN
        illegal_n    = illegal;
`endif
        // A Sys transfer beats a simultaneous redirect.
        if (redirect && (state != ST_HALTED) &&
            !((state == ST_HOLD) && xfer && is_sys)) begin
            pc_n         = redirect_pc;
            pre_loaded_n = 1'b0;
            valid_n      = 1'b0;
            state_n      = ST_FETCH;
        end else begin
            unique case (state)
                ST_FETCH: state_n = ST_WAIT;
                ST_WAIT: begin
`ifdef SIK_ILLEGAL_TRAP_EN
                    if (bad) begin
                        illegal_n = 1'b1;
                        opc_n     = pc;
                        state_n   = ST_HALTED;
                    end else
`endif
                    if (in_op == OP_PRE) begin
                        pre_reg_n    = imem_data[3:0];
                        pre_loaded_n = 1'b1;
                        pc_n         = pc + 1'b1;
                        state_n      = ST_FETCH;
                    end else begin
                        op_n         = in_op;
                        arg_n        = in_arg;
                        imm_n        = imm_w;
                        pu_n         = pre_used_w;
                        opc_n        = pc;
                        valid_n      = 1'b1;
                        pre_loaded_n = 1'b0;
                        pc_n         = pc + 1'b1;
                        state_n      = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (xfer) begin
                        valid_n = 1'b0;
                        state_n = is_sys ? ST_HALTED : ST_FETCH;
                    end
                end
                ST_HALTED: valid_n = 1'b0;
                default:   state_n = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_FETCH;
            pc           <= RESET_PC;
            pre_reg      <= '0;
            pre_loaded   <= 1'b0;
            out_valid    <= 1'b0;
            out_op       <= '0;
            out_arg      <= '0;
            out_imm      <= '0;
            out_pc       <= RESET_PC;
            out_pre_used <= 1'b0;
`ifdef SIK_ILLEGAL_TRAP_EN
            illegal      <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            pre_reg      <= pre_reg_n;
            pre_loaded   <= pre_loaded_n;
            out_valid    <= valid_n;
            out_op       <= op_n;
            out_arg      <= arg_n;
            out_imm      <= imm_n;
            out_pc       <= opc_n;
            out_pre_used <= pu_n;
`ifdef SIK_ILLEGAL_TRAP_EN
            illegal      <= illegal_n;
`endif
        end
    end

endmodule

// File: doc/sik_fetch_decode.md
Name: sik_fetch_decode

Overview:
Instruction fetch/decode front end for the SIK stack processor; sits directly upstream of the execute stage.
- Fetches 16-bit instruction words from a synchronous instruction memory.
- Folds Pre prefixes into a 16-bit immediate.
- Hands one decoded instruction at a time to execute over a valid/ready handshake.
- Accepts PC redirects from execute (Jump/JumpT/JumpF/Call/Ret) and stops fetching after Sys.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset.
PC_W, 16, PC/address width; instruction word is fixed at 16 bits.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clk).
imem_rd  out  1  read strobe; imem_data valid exactly one cycle later.
imem_addr  out  PC_W  read address.
imem_data  in  16  instruction word.
redirect  in  1  execute requests fetch from redirect_pc.
redirect_pc  in  PC_W  redirect target.
out_valid  out  1  decoded instruction available.
out_ready  in  1  execute accepts this cycle.
out_op  out  4  opcode, instr[15:12].
out_arg  out  12  instr[11:0].
out_imm  out  16  immediate (see Behaviour).
out_pc  out  PC_W  address of the delivered instruction.
out_pre_used  out  1  out_imm carries a Pre prefix.
halted  out  1  Sys delivered; fetching stopped.

Behaviour:
- Reset values: imem_rd=0, imem_addr=RESET_PC, out_valid=0, out_op/out_arg/out_imm=0, out_pc=RESET_PC, out_pre_used=0, halted=0, pre_loaded=0, state=FETCH. Reset mid-fetch discards any returning data.
- States:
  - FETCH: imem_rd=1, imem_addr=pc. Go to WAIT.
  - WAIT: capture imem_data.
    - If op==7 (Pre): pre_reg<=instr[3:0], pre_loaded<=1, pc<=pc+1, go to FETCH. Nothing is emitted. A later Pre overwrites an earlier one.
    - Otherwise: register outputs, out_valid<=1, pc<=pc+1, go to HOLD.
  - HOLD: outputs stable while out_valid&&!out_ready. On transfer (out_valid&&out_ready): out_valid<=0.
    - If the delivered instruction is Sys (op 0, arg 12'd512): go to HALTED.
    - Else: go to FETCH.
  - HALTED: halted=1, imem_rd=0, out_valid=0. Leave only via reset; redirect is ignored.
- Latency: 2 cycles from FETCH to out_valid; peak throughput 1 instruction per 3 cycles; each Pre adds 2 cycles.
- Immediate:
  - pre_loaded=1: out_imm={pre_reg, instr[11:0]}, out_pre_used=1. pre_loaded clears when the instruction is emitted, whatever its opcode (prefix on a NoArg op is consumed and ignored by execute).
  - pre_loaded=0: out_imm = sign-extend(instr[11:0]), out_pre_used=0.
- PC arithmetic is modulo 2^PC_W (16'hFFFF+1 -> 0).
- Redirect (any state except HALTED) has priority over normal sequencing:
  - pc<=redirect_pc, pre_loaded<=0, out_valid<=0 next cycle, go to FETCH.
  - A read outstanding in WAIT is discarded.
  - If redirect coincides with a transfer, the transfer counts; if it coincides with a transfer of Sys, HALTED wins.
- Opcodes 10..15 are passed through undecoded (execute halts on them) unless SIK_ILLEGAL_TRAP_EN.

Optional Feature:
SIK_ILLEGAL_TRAP_EN.
- Defined: adds output illegal (1 bit, reset 0). A word in WAIT with op>=10, or op==0 whose arg is not exactly one of the 12 one-hot NoArg codes, is not emitted; illegal<=1, halted<=1, state HALTED, out_pc holds the offending address.
- Undefined: no illegal port; such words are delivered unchanged.

Decomposition:
- Shared package `sik_defs`: opcode constants (NoArg..Put), the 12 NoArg one-hot codes, field ranges (OPCODE [15:12], ARG [11:0]), WORDSIZE, and the state encoding. The same package is used by execute.
- Optional sub-module `sik_imm_gen`: combinational immediate/prefix merge (instr, pre_reg, pre_loaded -> imm, pre_used).

Test Plan:
- Reset release, imem[0]=16'h8005 (Push 5) -> out_valid at cycle 2, out_op=8, out_imm=16'h0005, out_pc=0, out_pre_used=0.
- imem[0]=16'h700A (Pre A), imem[1]=16'h8123 -> a single output, out_imm=16'hA123, out_pre_used=1, out_pc=1; next Push 16'h8FFF -> out_imm=16'hFFFF, pre_used=0.
- Hold out_ready=0 for 5 cycles -> outputs stable, imem_rd=0 throughout; ready=1 -> one transfer only, fetch resumes at pc+1.
- Redirect to 16'h0040 during WAIT with a pending Pre -> returning word dropped, next imem_addr=16'h0040, pre_loaded cleared.
- pc=16'hFFFF -> next fetch at 16'h0000.
- Deliver Sys (16'h0200) -> halted=1 after transfer, imem_rd stays 0 despite redirect; reset=0 one cycle -> fetch restarts at RESET_PC. With SIK_ILLEGAL_TRAP_EN, 16'hB000 -> illegal=1, no out_valid.
